// File: rtl/sipo_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : sipo_frame_rx
// Brief   : Parametrised SIPO receive deserialiser with valid/ready holding stage
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sipo_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             sdata,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clear_ovr,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  // shift_word: register with the current bit appended.
  // restart_word: the current bit as the first bit of a freshly resynced frame.
  logic [WIDTH-1:0] shift_word;
  logic [WIDTH-1:0] restart_word;
  logic             complete;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_word   = {shreg_q[WIDTH-2:0], sdata};
      assign restart_word = {{(WIDTH-1){1'b0}}, sdata};
    end else begin : g_lsb_first
      assign shift_word   = {sdata, shreg_q[WIDTH-1:1]};
      assign restart_word = {sdata, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  assign complete = shift_en && (bit_count_q == LAST_BIT);

  always_comb begin
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (clear_ovr) overrun_d = 1'b0;

    // A completing word is accepted only if the holding stage is empty or
    // being drained on this same edge; otherwise it is dropped.
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shift_word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (frame_start) begin
      shreg_d     = shift_en ? restart_word : '0;
      bit_count_d = shift_en ? CNT_W'(1) : '0;
    end else if (shift_en) begin
      shreg_d     = shift_word;
      bit_count_d = complete ? '0 : bit_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q     <= '0;
      bit_count_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_count_q <= bit_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign bit_count = bit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_sipo_frame_rx
// Brief   : Directed self-checking bench for sipo_frame_rx (MSB- and LSB-first)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_frame_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       shift_en = 1'b0;
  logic       sdata = 1'b0;
  logic       frame_start = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_ovr = 1'b0;

  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic       m_ovr, l_ovr;
  logic [3:0] m_cnt, l_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sipo_frame_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset), .shift_en(shift_en), .sdata(sdata),
    .frame_start(frame_start), .out_data(m_data), .out_valid(m_valid),
    .out_ready(out_ready), .overrun(m_ovr), .clear_ovr(clear_ovr),
    .bit_count(m_cnt)
  );

  sipo_frame_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset), .shift_en(shift_en), .sdata(sdata),
    .frame_start(frame_start), .out_data(l_data), .out_valid(l_valid),
    .out_ready(out_ready), .overrun(l_ovr), .clear_ovr(clear_ovr),
    .bit_count(l_cnt)
  );

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic send_bit(input logic b, input logic fs, input logic rdy, input logic clr);
    @(negedge clock);
    shift_en    = 1'b1;
    sdata       = b;
    frame_start = fs;
    out_ready   = rdy;
    clear_ovr   = clr;
  endtask

  // Sends the top n bits of w, MSB first in time, holding out_ready as it is.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[7-i], 1'b0, out_ready, 1'b0);
  endtask

  // Idles the strobe; on return the outputs reflect the previous rising edge.
  task automatic settle();
    @(negedge clock);
    shift_en    = 1'b0;
    frame_start = 1'b0;
    clear_ovr   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checks += 5;
    if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    if (m_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", m_ovr); end
    if (m_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", m_cnt); end
    if (l_data !== 8'h00 || l_valid !== 1'b0) begin
      errors++; $display("FAIL reset_lsb: got data=%h valid=%b want 00/0", l_data, l_valid);
    end
  endtask

  task automatic test_msb_first();
    out_ready = 1'b1;
    send_bits(8'hA5, 3);
    settle();
    checks++;
    if (m_cnt !== 4'd3) begin errors++; $display("FAIL msb_partial_cnt: got %0d want 3", m_cnt); end
    send_bits(8'hA5 << 3, 5);
    settle();
    checks += 4;
    if (m_data !== 8'hA5) begin errors++; $display("FAIL msb_data: got %h want a5", m_data); end
    if (m_valid !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b want 1", m_valid); end
    if (m_cnt !== 4'd0) begin errors++; $display("FAIL msb_cnt_wrap: got %0d want 0", m_cnt); end
    if (l_data !== 8'hA5) begin errors++; $display("FAIL lsb_a5: got %h want a5", l_data); end
    settle();
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL msb_valid_one_cycle: got %b want 0", m_valid); end
  endtask

  task automatic test_lsb_first();
    out_ready = 1'b1;
    send_bits(8'hC0, 8);
    settle();
    checks += 3;
    if (l_data !== 8'h03) begin errors++; $display("FAIL lsb_data: got %h want 03", l_data); end
    if (l_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b want 1", l_valid); end
    if (m_data !== 8'hC0) begin errors++; $display("FAIL msb_c0: got %h want c0", m_data); end
    settle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_bits(8'h3C, 8);
    settle();
    checks += 2;
    if (m_data !== 8'h3C || m_valid !== 1'b1) begin
      errors++; $display("FAIL bp_first: got %h/%b want 3c/1", m_data, m_valid);
    end
    if (m_ovr !== 1'b0) begin errors++; $display("FAIL bp_no_ovr: got %b want 0", m_ovr); end
    send_bits(8'hC3, 8);
    settle();
    checks += 3;
    if (m_data !== 8'h3C) begin errors++; $display("FAIL bp_hold: got %h want 3c", m_data); end
    if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    if (m_ovr !== 1'b1) begin errors++; $display("FAIL bp_ovr: got %b want 1", m_ovr); end
    clear_ovr = 1'b1;
    settle();
    checks++;
    if (m_ovr !== 1'b0 || m_valid !== 1'b1) begin
      errors++; $display("FAIL bp_clear: got ovr=%b valid=%b want 0/1", m_ovr, m_valid);
    end
    out_ready = 1'b1;
    settle();
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", m_valid); end
  endtask

  task automatic test_simultaneous_accept();
    out_ready = 1'b0;
    send_bits(8'h11, 8);
    send_bits(8'h22, 7);
    send_bit(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    checks += 3;
    if (m_data !== 8'h22) begin errors++; $display("FAIL simul_data: got %h want 22", m_data); end
    if (m_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b want 1", m_valid); end
    if (m_ovr !== 1'b0) begin errors++; $display("FAIL simul_ovr: got %b want 0", m_ovr); end
    settle();
  endtask

  task automatic test_set_wins();
    out_ready = 1'b0;
    send_bits(8'h11, 8);
    send_bits(8'h22, 7);
    send_bit(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    checks++;
    if (m_ovr !== 1'b1 || m_data !== 8'h11) begin
      errors++; $display("FAIL set_wins: got ovr=%b data=%h want 1/11", m_ovr, m_data);
    end
    clear_ovr = 1'b1;
    out_ready = 1'b1;
    settle();
    settle();
  endtask

  task automatic test_resync();
    out_ready = 1'b1;
    send_bits(8'h1F, 5);
    settle();
    checks++;
    if (m_cnt !== 4'd5) begin errors++; $display("FAIL resync_partial: got %0d want 5", m_cnt); end
    send_bit(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    checks++;
    if (m_cnt !== 4'd1) begin errors++; $display("FAIL resync_cnt: got %0d want 1", m_cnt); end
    send_bits(8'hE0, 7);
    settle();
    checks++;
    if (m_data !== 8'hF0 || m_valid !== 1'b1) begin
      errors++; $display("FAIL resync_data: got %h/%b want f0/1", m_data, m_valid);
    end
    settle();
  endtask

  task automatic test_start_on_complete();
    out_ready = 1'b1;
    send_bits(8'h81, 7);
    send_bit(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    checks += 2;
    if (m_data !== 8'h81 || m_valid !== 1'b1) begin
      errors++; $display("FAIL soc_data: got %h/%b want 81/1", m_data, m_valid);
    end
    if (m_cnt !== 4'd1) begin errors++; $display("FAIL soc_cnt: got %0d want 1", m_cnt); end
    frame_start = 1'b1;
    settle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_bits(8'h11, 8);
    send_bits(8'hFF, 4);
    settle();
    checks++;
    if (m_cnt !== 4'd4 || m_valid !== 1'b1) begin
      errors++; $display("FAIL rm_pre: got cnt=%0d valid=%b want 4/1", m_cnt, m_valid);
    end
    reset = 1'b1;
    settle();
    reset = 1'b0;
    checks++;
    if (m_data !== 8'h00 || m_valid !== 1'b0 || m_ovr !== 1'b0 || m_cnt !== 4'd0) begin
      errors++; $display("FAIL rm_cleared: got %h/%b/%b/%0d want 00/0/0/0", m_data, m_valid, m_ovr, m_cnt);
    end
    out_ready = 1'b1;
    send_bits(8'h5A, 8);
    settle();
    checks++;
    if (m_data !== 8'h5A || m_valid !== 1'b1 || m_ovr !== 1'b0) begin
      errors++; $display("FAIL rm_after: got %h/%b/%b want 5a/1/0", m_data, m_valid, m_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_simultaneous_accept();
    test_set_wins();
    test_resync();
    test_start_on_complete();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
